// File: rtl/ddr_cmd_scheduler.sv
// Timing-aware DDR4 command scheduler: packs host commands into 4-slot 128-bit beats.
// Define SCHED_REF_EN to include the periodic precharge-all + refresh injector.
module ddr_cmd_scheduler #(
   parameter int unsigned T_RCD        = 16,
   parameter int unsigned T_RP         = 16,
   parameter int unsigned T_RAS        = 39,
   parameter int unsigned T_RFC        = 420,
   parameter int unsigned REF_INTERVAL = 1950
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  S_AXIS_TDATA,
   input  logic         S_AXIS_TVALID,
   output logic         S_AXIS_TREADY,
   output logic [127:0] M_AXIS_TDATA,
   output logic         M_AXIS_TVALID,
   input  logic         M_AXIS_TREADY,
   output logic         err_illegal,
   output logic         ref_busy,
   output logic [1:0]   o_ref_state
);
   localparam logic [2:0] OP_NOP = 3'd0, OP_PRE = 3'd1, OP_ACT = 3'd2;
   localparam logic [2:0] OP_RD  = 3'd3, OP_WR  = 3'd4, OP_REF = 3'd5;
   localparam logic [9:0] L_RCD = 10'(T_RCD), L_RP = 10'(T_RP);
   localparam logic [9:0] L_RAS = 10'(T_RAS), L_RFC = 10'(T_RFC);

   // Handshake: host beat moves on S_AXIS_TVALID && S_AXIS_TREADY at clk; output beat
   // is consumed on M_AXIS_TVALID && M_AXIS_TREADY and otherwise held stable.

   function automatic logic [9:0] f_need(input logic [9:0] t_a, input logic [9:0] e_a,
                                         input logic [9:0] t_b, input logic [9:0] e_b);
      logic [9:0] a, b;
      a = (t_a > e_a) ? t_a - e_a : 10'd0;
      b = (t_b > e_b) ? t_b - e_b : 10'd0;
      return (a > b) ? a : b;
   endfunction

   function automatic logic [9:0] f_next_e(input logic [9:0] e, input logic hit,
                                           input logic [1:0] slot);
      if (hit) return 10'd4 - {8'd0, slot};
      return (e > 10'd1019) ? 10'd1023 : e + 10'd4;
   endfunction

   logic          r_head_v;
   logic [31:0]   r_head;
   logic [9:0]    r_e_act, r_e_pre, r_e_ref;
   logic          r_err;
   logic [127:0]  r_tdata;
   logic          r_tvalid;

   logic          w_advance, w_cand_v, w_from_head, w_fit, w_place, w_head_issued;
   logic          w_accept, w_keep, w_ref_block;
   logic [31:0]   w_cand;
   logic [9:0]    w_need;
   logic [1:0]    w_slot;
   logic [127:0]  w_beat;

`ifdef SCHED_REF_EN
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PALL = 2'd1, ST_REF = 2'd2} ref_state_t;
   ref_state_t    r_state;
   logic          r_ref_pending;
   logic [15:0]   r_int_cnt;
   logic          w_expire;

   assign w_ref_block = r_ref_pending || (r_state != ST_IDLE);
   assign w_expire    = (r_int_cnt == 16'(REF_INTERVAL - 1));
   assign ref_busy    = w_ref_block;
   assign o_ref_state = r_state;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_ref_pending <= 1'b0;
         r_int_cnt     <= 16'd0;
      end else begin
         r_int_cnt <= w_expire ? 16'd0 : r_int_cnt + 16'd1;
         case (r_state)
            ST_IDLE: if (r_ref_pending) r_state <= ST_PALL;
            ST_PALL: if (w_place) r_state <= ST_REF;
            ST_REF: begin
               if (w_place) begin
                  r_state       <= ST_IDLE;
                  r_ref_pending <= 1'b0;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
         // A fresh expiry wins over the clear so no request is lost.
         if (w_expire) r_ref_pending <= 1'b1;
      end
   end
`else
   assign w_ref_block = 1'b0;
   assign ref_busy    = 1'b0;
   assign o_ref_state = 2'd0;
`endif

   always_comb begin
      w_cand_v    = r_head_v;
      w_cand      = r_head;
      w_from_head = r_head_v;
`ifdef SCHED_REF_EN
      if (r_state == ST_PALL) begin
         w_cand_v    = 1'b1;
         w_cand      = 32'h0000_0081;
         w_from_head = 1'b0;
      end else if (r_state == ST_REF) begin
         w_cand_v    = 1'b1;
         w_cand      = {29'd0, OP_REF};
         w_from_head = 1'b0;
      end else if (r_ref_pending) begin
         w_cand_v    = 1'b0;
         w_from_head = 1'b0;
      end
`endif
      case (w_cand[2:0])
         OP_ACT:        w_need = f_need(L_RP,  r_e_pre, L_RFC, r_e_ref);
         OP_RD, OP_WR:  w_need = f_need(L_RCD, r_e_act, L_RFC, r_e_ref);
         OP_PRE:        w_need = f_need(L_RAS, r_e_act, L_RFC, r_e_ref);
         OP_REF:        w_need = f_need(L_RP,  r_e_pre, L_RFC, r_e_ref);
         default:       w_need = 10'd0;
      endcase
   end

   assign w_advance     = !r_tvalid || M_AXIS_TREADY;
   assign w_fit         = (w_need < 10'd4);
   assign w_slot        = w_need[1:0];
   assign w_place       = w_advance && w_cand_v && w_fit;
   assign w_head_issued = w_place && w_from_head;
   assign w_beat        = {96'd0, w_cand} << {w_slot, 5'd0};

   assign S_AXIS_TREADY = (!r_head_v || w_head_issued) && !w_ref_block;
   assign w_accept      = S_AXIS_TVALID && S_AXIS_TREADY;
   // NOP and illegal opcodes never occupy the head, so they cannot produce a slot.
   assign w_keep        = (S_AXIS_TDATA[2:0] != OP_NOP) && (S_AXIS_TDATA[2:0] <= OP_REF);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_head_v <= 1'b0;
         r_head   <= 32'd0;
         r_e_act  <= 10'd1023;
         r_e_pre  <= 10'd1023;
         r_e_ref  <= 10'd1023;
         r_err    <= 1'b0;
         r_tdata  <= 128'd0;
         r_tvalid <= 1'b0;
      end else begin
         if (w_head_issued) r_head_v <= 1'b0;
         if (w_accept && w_keep) begin
            r_head_v <= 1'b1;
            r_head   <= S_AXIS_TDATA;
         end
         if (w_accept && (S_AXIS_TDATA[2:0] > OP_REF)) r_err <= 1'b1;
         // Elapsed counters only move on advance; a stall freezes them.
         if (w_advance) begin
            r_tdata  <= w_place ? w_beat : 128'd0;
            r_tvalid <= w_place;
            r_e_act  <= f_next_e(r_e_act, w_place && (w_cand[2:0] == OP_ACT), w_slot);
            r_e_pre  <= f_next_e(r_e_pre, w_place && (w_cand[2:0] == OP_PRE), w_slot);
            r_e_ref  <= f_next_e(r_e_ref, w_place && (w_cand[2:0] == OP_REF), w_slot);
         end
      end
   end

   assign M_AXIS_TDATA  = r_tdata;
   assign M_AXIS_TVALID = r_tvalid;
   assign err_illegal   = r_err;
endmodule
